data_memory_responder: RTL and testbench

- Data-memory target for the RISC-V datapath.
- Answers load/store requests raised by the datapath through `memoryRead`/`memoryWrite`, i.e. the responder end of the memory interface driven by the Controller.
- Word-addressed storage with a fixed, parameterised access latency and a one-cycle `ready` completion pulse.
- Flags misaligned, out-of-range and conflicting requests instead of performing them.

---
 rtl/datapath_pkg.sv | 54 +++++
 rtl/memory_array.sv | 31 +++
 rtl/data_memory_responder.sv | 208 ++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types and helpers for the datapath data-memory responder.
// Subword helpers are only referenced when SUBWORD_ACCESS_EN is defined.
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned WORD_BYTES = 4;

    // Pull the addressed byte/half out of a word and extend it per funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            F3_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
            F3_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   load_extract = {24'b0, sh[7:0]};
            F3_HU:   load_extract = {16'b0, sh[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_be(input logic [1:0] lane,
                                            input logic [2:0] f3);
        case (f3)
            F3_B:    store_be = 4'b0001 << lane;
            F3_H:    store_be = 4'b0011 << lane;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate the store data so every candidate lane carries it.
    function automatic logic [31:0] store_data(input logic [31:0] wd,
                                               input logic [2:0]  f3);
        case (f3)
            F3_B:    store_data = {4{wd[7:0]}};
            F3_H:    store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

endpackage

// File: rtl/memory_array.sv
// Word storage for the data-memory responder: synchronous byte-enabled
// write, combinational read. Contents are never reset.
module memory_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int AW         = 6
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: samples a load/store request in IDLE, waits a
// fixed LATENCY, then pulses ready (and error for rejected requests).
// Optional subword loads/stores are enabled by defining SUBWORD_ACCESS_EN.
module data_memory_responder
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memoryRead,
    input  logic                  memoryWrite,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] writeData,
`ifdef SUBWORD_ACCESS_EN
    input  logic [2:0]            funct3,
`endif
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  ready,
    output logic                  error,
    output logic                  busy
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OFS = $clog2(WORD_BYTES);
    localparam logic [31-OFS:0] DEPTH_IDX = (32 - OFS)'(DEPTH);
    localparam logic [3:0]      CNT_INIT  = 4'(LATENCY - 1);

    mem_state_t state;
    logic [3:0] cnt;

    // Request captured at the sampling edge
    logic                  lat_write;
    logic                  lat_err;
    logic [AW-1:0]         lat_idx;
    logic [DATA_WIDTH-1:0] lat_wdata;

    // Live decode of the inputs
    logic                  req;
    logic [31-OFS:0]       in_idx;
    logic                  in_err;

    // Request seen by the completion logic: live in IDLE, latched otherwise
    logic                  cur_write;
    logic                  cur_err;
    logic [AW-1:0]         cur_idx;
    logic [DATA_WIDTH-1:0] cur_wdata;

    logic                  enter_resp;
    logic                  mem_we;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] load_value;

`ifdef SUBWORD_ACCESS_EN
    logic [2:0] lat_f3;
    logic [1:0] lat_lane;
    logic [2:0] cur_f3;
    logic [1:0] cur_lane;
`endif

    assign req = memoryRead | memoryWrite;

    // Classify the incoming request as legal or rejected.
    always_comb begin
        in_idx = address[31:OFS];
        in_err = (memoryRead && memoryWrite) || (in_idx >= DEPTH_IDX);
`ifdef SUBWORD_ACCESS_EN
        if (memoryWrite) begin
            case (funct3)
                F3_B:    begin end
                F3_H:    if (address[0]) in_err = 1'b1;
                F3_W:    if (address[1:0] != 2'b00) in_err = 1'b1;
                default: in_err = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: begin end
                F3_H, F3_HU: if (address[0]) in_err = 1'b1;
                F3_W:        if (address[1:0] != 2'b00) in_err = 1'b1;
                default:     in_err = 1'b1;
            endcase
        end
`else
        if (address[OFS-1:0] != '0) in_err = 1'b1;
`endif
    end

    // With LATENCY=1 the array is accessed on the sampling edge itself,
    // so the live inputs are used in IDLE and the latched copy elsewhere.
    always_comb begin
        if (state == IDLE) begin
            cur_write = memoryWrite;
            cur_err   = in_err;
            cur_idx   = in_idx[AW-1:0];
            cur_wdata = writeData;
        end else begin
            cur_write = lat_write;
            cur_err   = lat_err;
            cur_idx   = lat_idx;
            cur_wdata = lat_wdata;
        end
`ifdef SUBWORD_ACCESS_EN
        if (state == IDLE) begin
            cur_f3   = funct3;
            cur_lane = address[1:0];
        end else begin
            cur_f3   = lat_f3;
            cur_lane = lat_lane;
        end
`endif
    end

    assign enter_resp = ((state == IDLE) && req && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == 4'd1));
    assign mem_we     = enter_resp && cur_write && !cur_err;

    // Shape write data, byte enables and load result for the access size.
    always_comb begin
`ifdef SUBWORD_ACCESS_EN
        mem_be     = NB'(store_be(cur_lane, cur_f3));
        mem_wdata  = DATA_WIDTH'(store_data(32'(cur_wdata), cur_f3));
        load_value = (!cur_write && !cur_err) ?
                     DATA_WIDTH'(load_extract(32'(mem_rdata), cur_lane, cur_f3)) : '0;
`else
        mem_be     = '1;
        mem_wdata  = cur_wdata;
        load_value = (!cur_write && !cur_err) ? mem_rdata : '0;
`endif
    end

    memory_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_array (
        .clock(clock),
        .we   (mem_we),
        .be   (mem_be),
        .addr (cur_idx),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // Request FSM with latency counter and registered completion outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            readData  <= '0;
            ready     <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
`ifdef SUBWORD_ACCESS_EN
            lat_f3    <= '0;
            lat_lane  <= '0;
`endif
        end else begin
            ready    <= 1'b0;
            error    <= 1'b0;
            readData <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_write <= memoryWrite;
                        lat_err   <= in_err;
                        lat_idx   <= in_idx[AW-1:0];
                        lat_wdata <= writeData;
`ifdef SUBWORD_ACCESS_EN
                        lat_f3    <= funct3;
                        lat_lane  <= address[1:0];
`endif
                        cnt  <= CNT_INIT;
                        busy <= 1'b1;
                        if (LATENCY == 1) state <= RESP;
                        else              state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                ready    <= 1'b1;
                error    <= cur_err;
                readData <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench: dut uses LATENCY=2, dut1 uses LATENCY=1.
module tb_data_memory_responder;
    import datapath_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic [2:0]  f30 = F3_W;
    logic [31:0] rdata0;
    logic        ready0, error0, busy0;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0, wd1 = '0;
    logic [2:0]  f31 = F3_W;
    logic [31:0] rdata1;
    logic        ready1, error1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_memory_responder #(.DATA_WIDTH(32), .DEPTH(64), .LATENCY(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .memoryRead (rd0),
        .memoryWrite(wr0),
        .address    (addr0),
        .writeData  (wd0),
`ifdef SUBWORD_ACCESS_EN
        .funct3     (f30),
`endif
        .readData   (rdata0),
        .ready      (ready0),
        .error      (error0),
        .busy       (busy0)
    );

    data_memory_responder #(.DATA_WIDTH(32), .DEPTH(64), .LATENCY(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .memoryRead (rd1),
        .memoryWrite(wr1),
        .address    (addr1),
        .writeData  (wd1),
`ifdef SUBWORD_ACCESS_EN
        .funct3     (f31),
`endif
        .readData   (rdata1),
        .ready      (ready1),
        .error      (error1),
        .busy       (busy1)
    );

    // Drive one request on the selected DUT and report what came back.
    task automatic access(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3,
                          output int lat, output logic [31:0] rdv,
                          output logic errv, output logic bsy,
                          output logic [31:0] post_rd, output logic post_rdy);
        lat = 0; rdv = '0; errv = 1'b0; bsy = 1'b0;
        @(negedge clock);
        if (sel) begin rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd; f31 = f3; end
        else     begin rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd; f30 = f3; end
        @(posedge clock);
        #1;
        bsy = sel ? busy1 : busy0;
        for (int i = 1; i <= 20; i++) begin
            if (sel ? ready1 : ready0) begin
                lat  = i;
                rdv  = sel ? rdata1 : rdata0;
                errv = sel ? error1 : error0;
                break;
            end
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        post_rd  = sel ? rdata1 : rdata0;
        post_rdy = sel ? ready1 : ready0;
        @(negedge clock);
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata0); end
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready0); end
        checks++; if (error0 !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", error0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy0); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_store_load;
        int lat; logic [31:0] rdv, prd; logic errv, bsy, prdy;
        access(0, 0, 1, 32'h10, 32'hDEADBEEF, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (lat !== 2) begin errors++; $display("FAIL st_latency got %0d want 2", lat); end
        checks++; if (errv !== 1'b0) begin errors++; $display("FAIL st_error got %b want 0", errv); end
        checks++; if (rdv !== 32'h0) begin errors++; $display("FAIL st_rdata got %h want 0", rdv); end
        checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL st_busy got %b want 1", bsy); end
        checks++; if (prdy !== 1'b0) begin errors++; $display("FAIL st_ready_pulse got %b want 0", prdy); end
        access(0, 1, 0, 32'h10, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ld_latency got %0d want 2", lat); end
        checks++; if (rdv !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata got %h want deadbeef", rdv); end
        checks++; if (errv !== 1'b0) begin errors++; $display("FAIL ld_error got %b want 0", errv); end
        checks++; if (prd !== 32'h0) begin errors++; $display("FAIL ld_rdata_after got %h want 0", prd); end
    endtask

    task automatic test_misaligned;
        int lat; logic [31:0] rdv, prd; logic errv, bsy, prdy;
        access(0, 1, 0, 32'h13, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency got %0d want 2", lat); end
        checks++; if (errv !== 1'b1) begin errors++; $display("FAIL mis_error got %b want 1", errv); end
        checks++; if (rdv !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h want 0", rdv); end
        access(0, 1, 0, 32'h10, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_reload got %h want deadbeef", rdv); end
    endtask

    task automatic test_range_conflict;
        int lat; logic [31:0] rdv, prd; logic errv, bsy, prdy;
        access(0, 0, 1, 32'h0, 32'h01020304, F3_W, lat, rdv, errv, bsy, prd, prdy);
        access(0, 0, 1, 32'h100, 32'hCAFEF00D, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (errv !== 1'b1) begin errors++; $display("FAIL range_error got %b want 1", errv); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL range_latency got %0d want 2", lat); end
        access(0, 1, 1, 32'h0, 32'h55555555, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (errv !== 1'b1) begin errors++; $display("FAIL conflict_error got %b want 1", errv); end
        checks++; if (rdv !== 32'h0) begin errors++; $display("FAIL conflict_rdata got %h want 0", rdv); end
        access(0, 1, 0, 32'h0, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'h01020304) begin errors++; $display("FAIL range_word0 got %h want 01020304", rdv); end
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] rdv, prd; logic errv, bsy, prdy;
        access(0, 0, 1, 32'h20, 32'h12345678, F3_W, lat, rdv, errv, bsy, prd, prdy);
        @(negedge clock);
        wr0 = 1'b1; addr0 = 32'h20; wd0 = 32'hFFFFFFFF;
        @(posedge clock);
        #1;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL abort_busy_wait got %b want 1", busy0); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy0); end
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", ready0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL abort_rdata got %h want 0", rdata0); end
        wr0 = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        access(0, 1, 0, 32'h20, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'h12345678) begin errors++; $display("FAIL abort_reload got %h want 12345678", rdv); end
    endtask

    task automatic test_ignore_inputs;
        int lat; logic [31:0] rdv, prd; logic errv, bsy, prdy;
        access(0, 0, 1, 32'h1C, 32'h11111111, F3_W, lat, rdv, errv, bsy, prd, prdy);
        @(negedge clock);
        wr0 = 1'b1; addr0 = 32'h18; wd0 = 32'h22222222;
        @(posedge clock);
        @(negedge clock);
        addr0 = 32'h1C; wd0 = 32'h33333333;
        @(posedge clock);
        #1;
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL ign_ready got %b want 1", ready0); end
        @(negedge clock);
        wr0 = 1'b0;
        access(0, 1, 0, 32'h18, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'h22222222) begin errors++; $display("FAIL ign_word18 got %h want 22222222", rdv); end
        access(0, 1, 0, 32'h1C, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'h11111111) begin errors++; $display("FAIL ign_word1c got %h want 11111111", rdv); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rdv, prd; logic errv, bsy, prdy;
        access(1, 0, 1, 32'h4, 32'h000000A5, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (lat !== 1) begin errors++; $display("FAIL l1_st_latency got %0d want 1", lat); end
        access(1, 1, 0, 32'h4, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (lat !== 1) begin errors++; $display("FAIL l1_ld_latency got %0d want 1", lat); end
        checks++; if (rdv !== 32'h000000A5) begin errors++; $display("FAIL l1_ld_rdata got %h want 000000a5", rdv); end
        // Store held, then switched to a load during RESP: one IDLE cycle between.
        @(negedge clock);
        wr1 = 1'b1; addr1 = 32'h8; wd1 = 32'h0000005A;
        @(posedge clock);
        #1;
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL b2b_st_ready got %b want 1", ready1); end
        @(negedge clock);
        wr1 = 1'b0; rd1 = 1'b1; addr1 = 32'h8;
        @(posedge clock);
        #1;
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_ready got %b want 0", ready1); end
        @(posedge clock);
        #1;
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL b2b_ld_ready got %b want 1", ready1); end
        checks++; if (rdata1 !== 32'h0000005A) begin errors++; $display("FAIL b2b_ld_rdata got %h want 0000005a", rdata1); end
        @(negedge clock);
        rd1 = 1'b0;
        repeat (2) @(posedge clock);
    endtask

`ifdef SUBWORD_ACCESS_EN
    task automatic test_subword;
        int lat; logic [31:0] rdv, prd; logic errv, bsy, prdy;
        access(0, 0, 1, 32'h8, 32'h80FF7F01, F3_W, lat, rdv, errv, bsy, prd, prdy);
        access(0, 1, 0, 32'h9, 32'h0, F3_B, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'h0000007F) begin errors++; $display("FAIL lb_9 got %h want 0000007f", rdv); end
        access(0, 1, 0, 32'hB, 32'h0, F3_B, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_b got %h want ffffff80", rdv); end
        access(0, 1, 0, 32'hA, 32'h0, F3_HU, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'h000080FF) begin errors++; $display("FAIL lhu_a got %h want 000080ff", rdv); end
        access(0, 1, 0, 32'h9, 32'h0, F3_H, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (errv !== 1'b1) begin errors++; $display("FAIL lh_mis_error got %b want 1", errv); end
        access(0, 0, 1, 32'hA, 32'h00000000, F3_B, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (errv !== 1'b0) begin errors++; $display("FAIL sb_error got %b want 0", errv); end
        access(0, 1, 0, 32'h8, 32'h0, F3_W, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (rdv !== 32'h80007F01) begin errors++; $display("FAIL lw_after_sb got %h want 80007f01", rdv); end
        access(0, 1, 0, 32'h8, 32'h0, 3'b011, lat, rdv, errv, bsy, prd, prdy);
        checks++; if (errv !== 1'b1) begin errors++; $display("FAIL f3_bad_error got %b want 1", errv); end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_range_conflict();
        test_reset_abort();
        test_ignore_inputs();
        test_back_to_back();
`ifdef SUBWORD_ACCESS_EN
        test_subword();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
